// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master round-robin Wishbone arbiter.
// Holds the ownership state encoding, the stall-counter width used when
// the optional WB_ARB_TIMEOUT_EN build is selected, and a small helper
// that turns a state into the one-hot grant vector.
package wb_arb_pkg;

    localparam int TMO_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    function automatic logic [1:0] grant_of(input arb_state_e st);
        logic [1:0] g;
        g = 2'b00;
        if (st == OWN0) g = 2'b01;
        if (st == OWN1) g = 2'b10;
        return g;
    endfunction

endpackage

// File: rtl/wb_arb_timeout.sv
// Stall watchdog for the arbiter's current owner (built only with
// WB_ARB_TIMEOUT_EN). Counts cycles where the slave sees a strobe but
// answers with neither ack nor err; when the count reaches the limit a
// single-cycle timeout pulse is raised and the count restarts.
module wb_arb_timeout
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic stall_i,
    input  logic clear_i,
    output logic tmo_o
);

    localparam logic [TMO_CNT_W-1:0] LIMIT = TMO_CNT_W'(TIMEOUT_CYCLES);

    logic [TMO_CNT_W-1:0] cnt_q;

    assign tmo_o = (cnt_q == LIMIT);

    // Stall counter: restarts after a timeout pulse, on any slave response,
    // or whenever no master owns the bus.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (tmo_o || clear_i) begin
            cnt_q <= '0;
        end else if (stall_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Two-master round-robin Wishbone arbiter in front of one shared slave.
// Ownership is a registered state; the winning master's bus fields are
// passed combinationally to the slave while it owns the bus. A master
// keeps the bus for as long as it holds cyc, and one idle cycle always
// separates consecutive grants.
// Optional build macro WB_ARB_TIMEOUT_EN adds a stall watchdog that
// pulses err to the owner after TIMEOUT_CYCLES unanswered strobe cycles.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner, slave outputs forced low, arbitration on m_cyc_i
// OWN0  | master 0 owns the slave until it drops m_cyc_i[0]
// OWN1  | master 1 owns the slave until it drops m_cyc_i[1]
module wb_arbiter_rr
    import wb_arb_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0]            m_cyc_i,
    input  logic [1:0]            m_stb_i,
    input  logic [1:0]            m_we_i,
    input  logic [2*AW-1:0]       m_adr_i,
    input  logic [2*DW-1:0]       m_dat_i,
    input  logic [2*(DW/8)-1:0]   m_sel_i,
    output logic [2*DW-1:0]       m_dat_o,
    output logic [1:0]            m_ack_o,
    output logic [1:0]            m_err_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [AW-1:0]         s_adr_o,
    output logic [DW-1:0]         s_dat_o,
    output logic [DW/8-1:0]       s_sel_o,
    input  logic [DW-1:0]         s_dat_i,
    input  logic                  s_ack_i,
    input  logic                  s_err_i,
    output logic [1:0]            grant_o
);

    localparam int SW = DW / 8;

    arb_state_e state_q;
    arb_state_e state_d;
    // Last master that was granted; on a tie the other one wins.
    logic       last_q;
    logic       own0;
    logic       own1;
    logic       tmo;

    assign own0    = (state_q == OWN0);
    assign own1    = (state_q == OWN1);
    assign grant_o = grant_of(state_q);

    // Next-owner decision: arbitrate only from IDLE, release on cyc drop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                case (m_cyc_i)
                    2'b01:   state_d = OWN0;
                    2'b10:   state_d = OWN1;
                    2'b11:   state_d = last_q ? OWN0 : OWN1;
                    default: state_d = IDLE;
                endcase
            end
            OWN0:    if (!m_cyc_i[0]) state_d = IDLE;
            OWN1:    if (!m_cyc_i[1]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ownership register and round-robin pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && state_d == OWN0) last_q <= 1'b0;
            if (state_q == IDLE && state_d == OWN1) last_q <= 1'b1;
        end
    end

    // Slave-side mux: the owner's fields pass straight through, idle drives zero.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        case (state_q)
            OWN0: begin
                s_cyc_o = m_cyc_i[0];
                s_stb_o = m_stb_i[0] & m_cyc_i[0];
                s_we_o  = m_we_i[0];
                s_adr_o = m_adr_i[0 +: AW];
                s_dat_o = m_dat_i[0 +: DW];
                s_sel_o = m_sel_i[0 +: SW];
            end
            OWN1: begin
                s_cyc_o = m_cyc_i[1];
                s_stb_o = m_stb_i[1] & m_cyc_i[1];
                s_we_o  = m_we_i[1];
                s_adr_o = m_adr_i[AW +: AW];
                s_dat_o = m_dat_i[DW +: DW];
                s_sel_o = m_sel_i[SW +: SW];
            end
            default: ;
        endcase
    end

    // Master-side return path: only the owner sees read data and responses.
    always_comb begin
        m_dat_o = '0;
        if (own0) m_dat_o[0 +: DW]  = s_dat_i;
        if (own1) m_dat_o[DW +: DW] = s_dat_i;
    end

`ifdef WB_ARB_TIMEOUT_EN
    wb_arb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .stall_i (s_stb_o & ~s_ack_i & ~s_err_i),
        .clear_i (s_ack_i | s_err_i | (state_q == IDLE)),
        .tmo_o   (tmo)
    );
`else
    assign tmo = 1'b0;
`endif

    assign m_ack_o = {own1 & s_ack_i, own0 & s_ack_i};
    assign m_err_o = {own1 & (s_err_i | tmo), own0 & (s_err_i | tmo)};

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Bench for wb_arbiter_rr: directed scenarios followed by random traffic.
// A driver applies inputs just after each rising edge and pushes the
// expected outputs for that cycle into a queue; a monitor pops on the
// falling edge and compares.
module tb_wb_arbiter_rr;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 4;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [1:0]        m_cyc_i, m_stb_i, m_we_i;
    logic [2*AW-1:0]   m_adr_i;
    logic [2*DW-1:0]   m_dat_i;
    logic [2*SW-1:0]   m_sel_i;
    logic [2*DW-1:0]   m_dat_o;
    logic [1:0]        m_ack_o, m_err_o, grant_o;
    logic              s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic [SW-1:0]     s_sel_o;
    logic [DW-1:0]     s_dat_i;
    logic              s_ack_i, s_err_i;

    always #5 clk_i = ~clk_i;

    wb_arbiter_rr #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .grant_o(grant_o)
    );

    typedef struct packed {
        logic [1:0]      grant;
        logic            s_cyc;
        logic            s_stb;
        logic            s_we;
        logic [AW-1:0]   s_adr;
        logic [DW-1:0]   s_dat;
        logic [SW-1:0]   s_sel;
        logic [1:0]      m_ack;
        logic [1:0]      m_err;
        logic [2*DW-1:0] m_dat;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference: owner is -1 (nobody), 0 or 1; last is the master served last;
    // stall is the length of the current unanswered-strobe run.
    int   owner       = -1;
    int   last        = 1;
    int   stall       = 0;
    bit   model_valid = 1'b0;
    bit   fix_en      = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare whatever the driver predicted for this cycle.
    always @(negedge clk_i) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("grant", 64'(grant_o), 64'(e.grant));
            chk("s_cyc", 64'(s_cyc_o), 64'(e.s_cyc));
            chk("s_stb", 64'(s_stb_o), 64'(e.s_stb));
            chk("s_we",  64'(s_we_o),  64'(e.s_we));
            chk("s_adr", 64'(s_adr_o), 64'(e.s_adr));
            chk("s_dat", 64'(s_dat_o), 64'(e.s_dat));
            chk("s_sel", 64'(s_sel_o), 64'(e.s_sel));
            chk("m_ack", 64'(m_ack_o), 64'(e.m_ack));
            chk("m_err", 64'(m_err_o), 64'(e.m_err));
            chk("m_dat", 64'(m_dat_o), 64'(e.m_dat));
        end
    end

    function automatic bit timeout_now();
        return TMO_EN && owner >= 0 && stall == TMO;
    endfunction

    // Apply the arbitration rules to the inputs that were present at this edge.
    task automatic model_advance();
        bit strobing;
        if (rst_i) begin
            owner       = -1;
            last        = 1;
            stall       = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            strobing = owner >= 0 && m_cyc_i[owner] && m_stb_i[owner];
            if (timeout_now() || owner < 0 || s_ack_i || s_err_i) stall = 0;
            else if (strobing) stall = stall + 1;
            if (owner < 0) begin
                if (m_cyc_i == 2'b01) owner = 0;
                else if (m_cyc_i == 2'b10) owner = 1;
                else if (m_cyc_i == 2'b11) owner = 1 - last;
                if (owner >= 0) last = owner;
            end else if (!m_cyc_i[owner]) begin
                owner = -1;
            end
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e = '0;
        if (owner >= 0) begin
            e.grant[owner]              = 1'b1;
            e.s_cyc                     = m_cyc_i[owner];
            e.s_stb                     = m_cyc_i[owner] & m_stb_i[owner];
            e.s_we                      = m_we_i[owner];
            e.s_adr                     = m_adr_i[owner*AW +: AW];
            e.s_dat                     = m_dat_i[owner*DW +: DW];
            e.s_sel                     = m_sel_i[owner*SW +: SW];
            e.m_ack[owner]              = s_ack_i;
            e.m_err[owner]              = s_err_i | timeout_now();
            e.m_dat[owner*DW +: DW]     = s_dat_i;
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input logic rst, input logic [1:0] cyc, input logic [1:0] stb,
                        input logic ack, input logic err);
        @(posedge clk_i);
        model_advance();
        #1;
        rst_i   = rst;
        m_cyc_i = cyc;
        m_stb_i = stb;
        m_we_i  = 2'($urandom);
        m_adr_i = {$urandom, $urandom};
        m_dat_i = {$urandom, $urandom};
        m_sel_i = 8'($urandom);
        s_dat_i = $urandom;
        s_ack_i = ack;
        s_err_i = err;
        if (fix_en) begin
            m_we_i[0]       = 1'b1;
            m_adr_i[AW-1:0] = 32'h0000_0100;
            m_dat_i[DW-1:0] = 32'hDEAD_BEEF;
            m_sel_i[SW-1:0] = 4'hF;
        end
        if (model_valid) push_expected();
    endtask

    initial begin
        int          busy[2];
        logic [1:0]  cyc, stb;
        rst_i = 1'b1; m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
        s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;

        step(1, 2'b00, 2'b00, 0, 0);
        step(0, 2'b00, 2'b00, 0, 0);

        // Master 0 alone: write 0x100 / 0xDEADBEEF, ack two cycles into the grant.
        fix_en = 1'b1;
        step(0, 2'b01, 2'b01, 0, 0);
        step(0, 2'b01, 2'b01, 0, 0);
        step(0, 2'b01, 2'b01, 0, 0);
        step(0, 2'b01, 2'b01, 1, 0);
        fix_en = 1'b0;
        step(0, 2'b00, 2'b00, 0, 0);
        step(0, 2'b00, 2'b00, 0, 0);

        // Ties after reset alternate 0, 1, 0.
        step(1, 2'b00, 2'b00, 0, 0);
        for (int r = 0; r < 3; r++) begin
            step(0, 2'b11, 2'b11, 0, 0);
            step(0, 2'b11, 2'b11, 1, 0);
            step(0, 2'b00, 2'b00, 0, 0);
        end
        step(0, 2'b00, 2'b00, 0, 0);

        // Master 1 owns, master 0 arrives mid-cycle and must wait.
        step(0, 2'b10, 2'b10, 0, 0);
        step(0, 2'b10, 2'b10, 0, 0);
        step(0, 2'b11, 2'b11, 1, 0);
        step(0, 2'b11, 2'b11, 1, 0);
        step(0, 2'b01, 2'b01, 0, 0);
        step(0, 2'b01, 2'b01, 0, 0);
        step(0, 2'b01, 2'b01, 1, 0);
        step(0, 2'b00, 2'b00, 0, 0);
        step(0, 2'b00, 2'b00, 0, 0);

        // Reset during a master 1 read with the ack arriving afterwards.
        step(0, 2'b10, 2'b10, 0, 0);
        step(0, 2'b10, 2'b10, 0, 0);
        step(1, 2'b10, 2'b10, 0, 0);
        step(0, 2'b10, 2'b10, 1, 0);
        step(0, 2'b00, 2'b00, 1, 0);
        step(0, 2'b00, 2'b00, 0, 0);
        step(0, 2'b00, 2'b00, 0, 0);

        // Slave never answers: watchdog pulse (or nothing in the default build).
        for (int i = 0; i < 12; i++) step(0, 2'b01, 2'b01, 0, 0);
        step(0, 2'b00, 2'b00, 0, 0);
        step(0, 2'b00, 2'b00, 0, 0);

        // Random traffic: masters hold cyc for random bursts with pulsed stb.
        busy[0] = 0; busy[1] = 0;
        for (int i = 0; i < 2000; i++) begin
            for (int n = 0; n < 2; n++) begin
                if (busy[n] > 0) busy[n]--;
                else if ($urandom_range(3) == 0) busy[n] = int'($urandom_range(10, 1));
                cyc[n] = busy[n] > 0;
                stb[n] = cyc[n] & ($urandom_range(3) != 0);
            end
            step(($urandom_range(99) == 0), cyc, stb,
                 ($urandom_range(3) == 0), ($urandom_range(15) == 0));
        end
        step(0, 2'b00, 2'b00, 0, 0);

        @(negedge clk_i);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
